// File: rtl/calc_pkg.sv
// calc_pkg: shared definitions for the accumulator calculator core.
//   OP_W         - width of the operation select field
//   calc_op_e    - operation encodings driven on op_in
//   calc_state_e - control FSM states (IDLE, MUL)
package calc_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_OR  = 3'd2,
    OP_EQ  = 3'd3,
    OP_AND = 3'd4,
    OP_XOR = 3'd5,
    OP_MUL = 3'd6,
    OP_CLR = 3'd7
  } calc_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } calc_state_e;

endpackage

// File: rtl/calc_accum_core_if.sv
// calc_accum_core_if: operand/button/status bundle of the calculator core.
//   num_in, op_in       - operand and operation select (quasi-static)
//   enter, undo         - raw asynchronous button levels
//   acc_out, carry, ovf, zero, busy, hist_cnt - registered status outputs
// Modports: master drives operands/buttons, slave is the core.
interface calc_accum_core_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) ();
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]          num_in;
  logic [calc_pkg::OP_W-1:0] op_in;
  logic                      enter;
  logic                      undo;
  logic [WIDTH-1:0]          acc_out;
  logic                      carry;
  logic                      ovf;
  logic                      zero;
  logic                      busy;
  logic [CNT_W-1:0]          hist_cnt;

  modport master (
    output num_in, op_in, enter, undo,
    input  acc_out, carry, ovf, zero, busy, hist_cnt
  );

  modport slave (
    input  num_in, op_in, enter, undo,
    output acc_out, carry, ovf, zero, busy, hist_cnt
  );
endinterface

// File: rtl/calc_sync_edge.sv
// calc_sync_edge: two-flop synchroniser followed by a rising-edge detector.
//   clk, rst_n - clock and asynchronous active-low reset
//   async_i    - raw asynchronous level (button)
//   pulse_o    - one-cycle pulse per low-to-high transition of async_i
module calc_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic pulse_o
);
  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  // Only the synchronised level is compared, so a held button gives one pulse.
  assign pulse_o = sync_q & ~prev_q;
endmodule

// File: rtl/calc_accum_core.sv
// calc_accum_core: parametrised accumulator calculator with iterative
// multiply, status flags and a circular undo history.
//   clk, rst_n - clock and asynchronous active-low reset
//   bus        - calc_accum_core_if.slave (operands, buttons, status)
module calc_accum_core
  import calc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  calc_accum_core_if.slave  bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BC_W  = $clog2(WIDTH);

  logic ent_p;
  logic und_p;

  calc_sync_edge u_sync_enter (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (bus.enter),
    .pulse_o (ent_p)
  );

  calc_sync_edge u_sync_undo (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (bus.undo),
    .pulse_o (und_p)
  );

  calc_state_e        state_q;
  logic [WIDTH-1:0]   acc_q;
  logic               carry_q;
  logic               ovf_q;
  logic               zero_q;
  logic               busy_q;
  logic [CNT_W-1:0]   hist_cnt_q;
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [BC_W-1:0]    bit_cnt_q;

  logic [WIDTH-1:0]   hist_mem [DEPTH];

  calc_op_e           op;
  logic [WIDTH:0]     sum_w;
  logic [WIDTH:0]     diff_w;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_carry;
  logic [2*WIDTH-1:0] prod_d;
  logic               mul_last;
  logic               push_now;
  logic               pop_now;
  logic [PTR_W-1:0]   wr_ptr_inc;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   cnt_push;
  logic [WIDTH-1:0]   hist_top;

  assign op = calc_op_e'(bus.op_in);

  // Single-cycle ALU for every op except MUL.
  always_comb begin
    sum_w     = {1'b0, acc_q} + {1'b0, bus.num_in};
    diff_w    = {1'b0, acc_q} - {1'b0, bus.num_in};
    alu_res   = '0;
    alu_carry = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res   = sum_w[WIDTH-1:0];
        alu_carry = sum_w[WIDTH];
      end
      OP_SUB: begin
        alu_res   = diff_w[WIDTH-1:0];
        // The extra bit of the extended difference is set exactly when num > acc.
        alu_carry = diff_w[WIDTH];
      end
      OP_OR:   alu_res = acc_q | bus.num_in;
      OP_EQ:   alu_res = {{(WIDTH-1){1'b0}}, (acc_q == bus.num_in)};
      OP_AND:  alu_res = acc_q & bus.num_in;
      OP_XOR:  alu_res = acc_q ^ bus.num_in;
      default: alu_res = '0;
    endcase
  end

  // Shift-add step: the multiplicand is pre-shifted, the multiplier's LSB
  // gates its addition into the partial product.
  assign prod_d   = prod_q + (mplier_q[0] ? mcand_q : '0);
  assign mul_last = (bit_cnt_q == BC_W'(WIDTH - 1));

  // Enter takes priority over undo in the same cycle.
  assign push_now = ((state_q == IDLE) && ent_p && (op != OP_MUL)) ||
                    ((state_q == MUL) && mul_last);
  assign pop_now  = (state_q == IDLE) && !ent_p && und_p && (hist_cnt_q != '0);

  assign wr_ptr_inc = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
  assign rd_ptr     = (wr_ptr_q == '0) ? PTR_W'(DEPTH - 1) : wr_ptr_q - 1'b1;
  assign cnt_push   = (hist_cnt_q == CNT_W'(DEPTH)) ? hist_cnt_q : hist_cnt_q + 1'b1;
  assign hist_top   = hist_mem[rd_ptr];

  // History storage needs no reset; only the pointer and count are meaningful.
  always_ff @(posedge clk) begin
    if (push_now) begin
      hist_mem[wr_ptr_q] <= acc_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      carry_q    <= 1'b0;
      ovf_q      <= 1'b0;
      zero_q     <= 1'b1;
      busy_q     <= 1'b0;
      hist_cnt_q <= '0;
      wr_ptr_q   <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      prod_q     <= '0;
      bit_cnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ent_p) begin
            if (op == OP_MUL) begin
              mcand_q   <= {{WIDTH{1'b0}}, acc_q};
              mplier_q  <= bus.num_in;
              prod_q    <= '0;
              bit_cnt_q <= '0;
              busy_q    <= 1'b1;
              state_q   <= MUL;
            end else begin
              acc_q      <= alu_res;
              carry_q    <= alu_carry;
              ovf_q      <= 1'b0;
              zero_q     <= (alu_res == '0);
              wr_ptr_q   <= wr_ptr_inc;
              hist_cnt_q <= cnt_push;
            end
          end else if (pop_now) begin
            acc_q      <= hist_top;
            carry_q    <= 1'b0;
            ovf_q      <= 1'b0;
            zero_q     <= (hist_top == '0);
            wr_ptr_q   <= rd_ptr;
            hist_cnt_q <= hist_cnt_q - 1'b1;
          end
        end
        MUL: begin
          prod_q    <= prod_d;
          mcand_q   <= mcand_q << 1;
          mplier_q  <= mplier_q >> 1;
          bit_cnt_q <= bit_cnt_q + 1'b1;
          if (mul_last) begin
            acc_q      <= prod_d[WIDTH-1:0];
            ovf_q      <= |prod_d[2*WIDTH-1:WIDTH];
            carry_q    <= 1'b0;
            zero_q     <= (prod_d[WIDTH-1:0] == '0);
            busy_q     <= 1'b0;
            wr_ptr_q   <= wr_ptr_inc;
            hist_cnt_q <= cnt_push;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.acc_out  = acc_q;
  assign bus.carry    = carry_q;
  assign bus.ovf      = ovf_q;
  assign bus.zero     = zero_q;
  assign bus.busy     = busy_q;
  assign bus.hist_cnt = hist_cnt_q;
endmodule

// File: tb/tb_calc_accum_core.sv
// tb_calc_accum_core: directed test of calc_accum_core with WIDTH=8, DEPTH=4.
module tb_calc_accum_core;
  import calc_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_bad = 0;

  calc_accum_core_if #(.WIDTH(8), .DEPTH(4)) bus ();

  calc_accum_core #(.WIDTH(8), .DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Press enter for 'hold' cycles, then leave time for the op to commit.
  task automatic do_op(input calc_op_e o, input logic [7:0] n, input int hold);
    @(negedge clk);
    bus.op_in  = o;
    bus.num_in = n;
    bus.enter  = 1'b1;
    repeat (hold) @(negedge clk);
    bus.enter = 1'b0;
    repeat (3) @(negedge clk);
    $display("op %0d num %0d -> acc %0d carry %0b ovf %0b zero %0b hist %0d",
             o, n, bus.acc_out, bus.carry, bus.ovf, bus.zero, bus.hist_cnt);
  endtask

  task automatic do_undo();
    @(negedge clk);
    bus.undo = 1'b1;
    @(negedge clk);
    bus.undo = 1'b0;
    repeat (3) @(negedge clk);
    $display("undo -> acc %0d hist %0d", bus.acc_out, bus.hist_cnt);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_op(OP_ADD, 8'd5, 1);
    n_vec++;
    if (bus.acc_out !== 8'd5) begin
      n_bad++; $display("FAIL rst_pre_acc got %0d exp 5", bus.acc_out);
    end
    // Assert reset mid-cycle; outputs must clear without a clock edge.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({bus.acc_out, bus.carry, bus.ovf, bus.zero, bus.busy, bus.hist_cnt} !== {8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0}) begin
      n_bad++;
      $display("FAIL rst_vals got acc %0d c %0b o %0b z %0b b %0b h %0d exp 0 0 0 1 0 0",
               bus.acc_out, bus.carry, bus.ovf, bus.zero, bus.busy, bus.hist_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    $display("reset -> acc %0d zero %0b", bus.acc_out, bus.zero);
  endtask

  task automatic test_add_wrap();
    apply_reset();
    do_op(OP_ADD, 8'd200, 1);
    n_vec++;
    if (bus.acc_out !== 8'd200 || bus.carry !== 1'b0) begin
      n_bad++; $display("FAIL add200 got %0d c %0b exp 200 c 0", bus.acc_out, bus.carry);
    end
    do_op(OP_ADD, 8'd100, 20);
    n_vec++;
    if (bus.acc_out !== 8'd44 || bus.carry !== 1'b1) begin
      n_bad++; $display("FAIL add_wrap got %0d c %0b exp 44 c 1", bus.acc_out, bus.carry);
    end
    n_vec++;
    if (bus.hist_cnt !== 3'd2 || bus.zero !== 1'b0) begin
      n_bad++; $display("FAIL add_hold hist %0d z %0b exp 2 z 0", bus.hist_cnt, bus.zero);
    end
  endtask

  task automatic test_sub_eq();
    do_op(OP_CLR, 8'd0, 1);
    n_vec++;
    if (bus.acc_out !== 8'd0 || bus.zero !== 1'b1 || bus.carry !== 1'b0) begin
      n_bad++; $display("FAIL clr got %0d z %0b c %0b exp 0 z 1 c 0", bus.acc_out, bus.zero, bus.carry);
    end
    do_op(OP_ADD, 8'd3, 1);
    do_op(OP_SUB, 8'd5, 1);
    n_vec++;
    if (bus.acc_out !== 8'd254 || bus.carry !== 1'b1) begin
      n_bad++; $display("FAIL sub_borrow got %0d c %0b exp 254 c 1", bus.acc_out, bus.carry);
    end
    do_op(OP_EQ, 8'd254, 1);
    n_vec++;
    if (bus.acc_out !== 8'd1 || bus.carry !== 1'b0 || bus.zero !== 1'b0) begin
      n_bad++; $display("FAIL eq got %0d c %0b z %0b exp 1 c 0 z 0", bus.acc_out, bus.carry, bus.zero);
    end
    do_op(OP_XOR, 8'hA5, 1);
    n_vec++;
    if (bus.acc_out !== 8'hA4) begin
      n_bad++; $display("FAIL xor got %0h exp a4", bus.acc_out);
    end
    do_op(OP_AND, 8'h0F, 1);
    n_vec++;
    if (bus.acc_out !== 8'h04) begin
      n_bad++; $display("FAIL and got %0h exp 04", bus.acc_out);
    end
    do_op(OP_OR, 8'h30, 1);
    n_vec++;
    if (bus.acc_out !== 8'h34) begin
      n_bad++; $display("FAIL or got %0h exp 34", bus.acc_out);
    end
  endtask

  task automatic test_mul();
    int busy_cycles;
    apply_reset();
    do_op(OP_ADD, 8'd20, 1);
    busy_cycles = 0;
    @(negedge clk);
    bus.op_in  = OP_MUL;
    bus.num_in = 8'd13;
    bus.enter  = 1'b1;
    @(negedge clk);
    bus.enter = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.busy === 1'b1) busy_cycles++;
      if (i == 2) begin
        bus.enter  = 1'b1;
        bus.op_in  = OP_ADD;
        bus.num_in = 8'd99;
      end
      if (i == 4) bus.enter = 1'b0;
      if (i == 1) begin
        n_vec++;
        if (bus.busy !== 1'b1) begin
          n_bad++; $display("FAIL mul_busy_rise got %0b exp 1", bus.busy);
        end
      end
      if (i == 9) begin
        n_vec++;
        if (bus.busy !== 1'b0 || bus.acc_out !== 8'd4) begin
          n_bad++; $display("FAIL mul_done got busy %0b acc %0d exp busy 0 acc 4", bus.busy, bus.acc_out);
        end
      end
    end
    $display("mul 20*13 -> acc %0d ovf %0b busy_cycles %0d", bus.acc_out, bus.ovf, busy_cycles);
    n_vec++;
    if (busy_cycles != 8) begin
      n_bad++; $display("FAIL mul_busy_len got %0d exp 8", busy_cycles);
    end
    n_vec++;
    if (bus.acc_out !== 8'd4 || bus.ovf !== 1'b1 || bus.carry !== 1'b0) begin
      n_bad++; $display("FAIL mul_result got %0d ovf %0b c %0b exp 4 ovf 1 c 0", bus.acc_out, bus.ovf, bus.carry);
    end
    n_vec++;
    if (bus.hist_cnt !== 3'd2) begin
      n_bad++; $display("FAIL mul_hist got %0d exp 2", bus.hist_cnt);
    end
    // A following op must clear ovf.
    do_op(OP_ADD, 8'd1, 1);
    n_vec++;
    if (bus.acc_out !== 8'd5 || bus.ovf !== 1'b0) begin
      n_bad++; $display("FAIL post_mul_add got %0d ovf %0b exp 5 ovf 0", bus.acc_out, bus.ovf);
    end
  endtask

  task automatic test_undo();
    logic [7:0] exp_acc [4];
    exp_acc[0] = 8'd4; exp_acc[1] = 8'd3; exp_acc[2] = 8'd2; exp_acc[3] = 8'd1;
    apply_reset();
    for (int i = 0; i < 5; i++) do_op(OP_ADD, 8'd1, 1);
    n_vec++;
    if (bus.acc_out !== 8'd5 || bus.hist_cnt !== 3'd4) begin
      n_bad++; $display("FAIL undo_fill got %0d hist %0d exp 5 hist 4", bus.acc_out, bus.hist_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      do_undo();
      n_vec++;
      if (bus.acc_out !== exp_acc[i] || bus.hist_cnt !== 3'(3 - i)) begin
        n_bad++; $display("FAIL undo_%0d got %0d hist %0d exp %0d hist %0d",
                          i, bus.acc_out, bus.hist_cnt, exp_acc[i], 3 - i);
      end
    end
    do_undo();
    n_vec++;
    if (bus.acc_out !== 8'd1 || bus.hist_cnt !== 3'd0) begin
      n_bad++; $display("FAIL undo_empty got %0d hist %0d exp 1 hist 0", bus.acc_out, bus.hist_cnt);
    end
  endtask

  task automatic test_enter_undo_same();
    @(negedge clk);
    bus.op_in  = OP_ADD;
    bus.num_in = 8'd2;
    bus.enter  = 1'b1;
    bus.undo   = 1'b1;
    @(negedge clk);
    bus.enter = 1'b0;
    bus.undo  = 1'b0;
    repeat (3) @(negedge clk);
    $display("enter+undo -> acc %0d hist %0d", bus.acc_out, bus.hist_cnt);
    n_vec++;
    if (bus.acc_out !== 8'd3 || bus.hist_cnt !== 3'd1) begin
      n_bad++; $display("FAIL enter_undo got %0d hist %0d exp 3 hist 1", bus.acc_out, bus.hist_cnt);
    end
  endtask

  task automatic test_reset_mid_mul();
    @(negedge clk);
    bus.op_in  = OP_MUL;
    bus.num_in = 8'd3;
    bus.enter  = 1'b1;
    @(negedge clk);
    bus.enter = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if (bus.busy !== 1'b1) begin
      n_bad++; $display("FAIL midmul_busy got %0b exp 1", bus.busy);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (bus.busy !== 1'b0 || bus.acc_out !== 8'd0 || bus.zero !== 1'b1 || bus.hist_cnt !== 3'd0) begin
      n_bad++; $display("FAIL midmul_rst got busy %0b acc %0d z %0b hist %0d exp 0 0 1 0",
                        bus.busy, bus.acc_out, bus.zero, bus.hist_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    n_vec++;
    if (bus.acc_out !== 8'd0 || bus.busy !== 1'b0) begin
      n_bad++; $display("FAIL midmul_abandon got acc %0d busy %0b exp 0 0", bus.acc_out, bus.busy);
    end
    do_op(OP_ADD, 8'd7, 1);
    n_vec++;
    if (bus.acc_out !== 8'd7 || bus.hist_cnt !== 3'd1) begin
      n_bad++; $display("FAIL midmul_add7 got %0d hist %0d exp 7 hist 1", bus.acc_out, bus.hist_cnt);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    bus.num_in = '0;
    bus.op_in  = '0;
    bus.enter  = 1'b0;
    bus.undo   = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_add_wrap();
    test_sub_eq();
    test_mul();
    test_undo();
    test_enter_undo_same();
    test_reset_mid_mul();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
